// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode, funct, ALU and mux-select codes
package cpu_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_RESET    = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_FETCH_LD = 4'd2;
  localparam state_t S_DECODE   = 4'd3;
  localparam state_t S_R        = 4'd4;
  localparam state_t S_ADDI     = 4'd5;
  localparam state_t S_WB_R     = 4'd6;
  localparam state_t S_WB_I     = 4'd7;
  localparam state_t S_BRANCH   = 4'd8;
  localparam state_t S_JUMP     = 4'd9;
  localparam state_t S_MEM_ADDR = 4'd10;
  localparam state_t S_MEM_WR   = 4'd11;
  localparam state_t S_MEM_RD   = 4'd12;
  localparam state_t S_MEM_WB   = 4'd13;
  localparam state_t S_HALT     = 4'd14;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - FUNCT field to ALUControl decoder for R-type instructions
module alu_dec
  import cpu_ctrl_pkg::*;
#(
  parameter int CODE_W = 6
) (
  input  logic [CODE_W-1:0] funct,
  output logic [2:0]        op,
  output logic              valid
);

  always_comb begin
    op    = ALU_PASS;
    valid = 1'b0;
    case (funct)
      FN_ADD: begin op = ALU_ADD; valid = 1'b1; end
      FN_SUB: begin op = ALU_SUB; valid = 1'b1; end
      FN_AND: begin op = ALU_AND; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle MIPS-style Moore control FSM with memory latency wait
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CODE_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] OPCODE,
  input  logic [CODE_W-1:0] FUNCT,
  input  logic              Zero,
  input  logic              Overflow,
  output logic              PCwrite,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              ALUOutWrite,
  output logic              AWrite,
  output logic              BWrite,
  output logic              MemToReg,
  output logic              RegDest,
  output logic              IorD,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSource,
  output logic [2:0]        ALUControl,
  output logic              Halted,
  output logic [3:0]        State
);

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  state_t     state, next_state;
  logic [1:0] wait_cnt;
  logic       wait_done;
  logic [2:0] alu_op;
  logic       funct_ok;
  logic       arith;

  alu_dec #(.CODE_W(CODE_W)) u_alu_dec (
    .funct (FUNCT),
    .op    (alu_op),
    .valid (funct_ok)
  );

  assign wait_done = (wait_cnt == 2'd0);
  assign arith     = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);

  // Counter reloads only on entry to a memory-wait state, then counts down to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RESET;
      wait_cnt <= 2'd0;
    end else begin
      state <= next_state;
      if ((next_state == S_FETCH  && state != S_FETCH) ||
          (next_state == S_MEM_RD && state != S_MEM_RD))
        wait_cnt <= LAT_LOAD;
      else if (!wait_done)
        wait_cnt <= wait_cnt - 2'd1;
    end
  end

  always_comb begin
    next_state = S_HALT;
    case (state)
      S_RESET:    next_state = S_FETCH;
      S_FETCH:    next_state = wait_done ? S_FETCH_LD : S_FETCH;
      S_FETCH_LD: next_state = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_R:          next_state = S_R;
          OP_ADDI:       next_state = S_ADDI;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          default:       next_state = S_HALT;
        endcase
      end
      S_R:        next_state = (!funct_ok || (arith && Overflow)) ? S_HALT : S_WB_R;
      S_ADDI:     next_state = Overflow ? S_HALT : S_WB_I;
      S_MEM_ADDR: next_state = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   next_state = wait_done ? S_MEM_WB : S_MEM_RD;
      S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_MEM_WR, S_MEM_WB:
                  next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_HALT;
    endcase
  end

  always_comb begin
    PCwrite     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUOutWrite = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    MemToReg    = 1'b0;
    RegDest     = 1'b0;
    IorD        = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    ALUControl  = ALU_PASS;
    case (state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCwrite    = 1'b1;
      end
      S_FETCH_LD: IRWrite = 1'b1;
      S_DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        ALUSrcB     = SRCB_IMM_SH;
        ALUControl  = ALU_ADD;
        ALUOutWrite = 1'b1;
      end
      S_R: begin
        ALUSrcA     = 1'b1;
        ALUControl  = alu_op;
        ALUOutWrite = 1'b1;
      end
      S_ADDI, S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUControl  = ALU_ADD;
        ALUOutWrite = 1'b1;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      S_WB_I: RegWrite = 1'b1;
      // The only Mealy-style term: the branch decision uses the live Zero flag.
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSource   = PCSRC_OUT;
        PCwrite    = (OPCODE == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCwrite  = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEM_RD: IorD = 1'b1;
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      default: ;
    endcase
  end

  assign Halted = (state == S_HALT);
  assign State  = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit at MEM_LAT=1 and MEM_LAT=2
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] OPCODE = 6'h00;
  logic [5:0] FUNCT = 6'h20;
  logic       Zero = 1'b0;
  logic       Overflow = 1'b0;

  logic a_PCwrite, a_MemWrite, a_IRWrite, a_RegWrite, a_ALUOutWrite, a_AWrite, a_BWrite;
  logic a_MemToReg, a_RegDest, a_IorD, a_ALUSrcA, a_Halted;
  logic [1:0] a_ALUSrcB, a_PCSource;
  logic [2:0] a_ALUControl;
  logic [3:0] a_State;
  logic b_PCwrite, b_MemWrite, b_IRWrite, b_RegWrite, b_ALUOutWrite, b_AWrite, b_BWrite;
  logic b_MemToReg, b_RegDest, b_IorD, b_ALUSrcA, b_Halted;
  logic [1:0] b_ALUSrcB, b_PCSource;
  logic [2:0] b_ALUControl;
  logic [3:0] b_State;

  control_unit #(.MEM_LAT(1), .CODE_W(6)) dut_a (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Zero(Zero), .Overflow(Overflow),
    .PCwrite(a_PCwrite), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegWrite(a_RegWrite),
    .ALUOutWrite(a_ALUOutWrite), .AWrite(a_AWrite), .BWrite(a_BWrite), .MemToReg(a_MemToReg),
    .RegDest(a_RegDest), .IorD(a_IorD), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
    .PCSource(a_PCSource), .ALUControl(a_ALUControl), .Halted(a_Halted), .State(a_State)
  );

  control_unit #(.MEM_LAT(2), .CODE_W(6)) dut_b (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Zero(Zero), .Overflow(Overflow),
    .PCwrite(b_PCwrite), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite),
    .ALUOutWrite(b_ALUOutWrite), .AWrite(b_AWrite), .BWrite(b_BWrite), .MemToReg(b_MemToReg),
    .RegDest(b_RegDest), .IorD(b_IorD), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .PCSource(b_PCSource), .ALUControl(b_ALUControl), .Halted(b_Halted), .State(b_State)
  );

  always #5 clk = ~clk;

  // en = {PCwrite, MemWrite, IRWrite, RegWrite, RegDest, MemToReg, Halted}
  // sel = {ALUSrcB, PCSource, ALUControl}
  logic [6:0] a_en, b_en, a_sel, b_sel;
  assign a_en  = {a_PCwrite, a_MemWrite, a_IRWrite, a_RegWrite, a_RegDest, a_MemToReg, a_Halted};
  assign b_en  = {b_PCwrite, b_MemWrite, b_IRWrite, b_RegWrite, b_RegDest, b_MemToReg, b_Halted};
  assign a_sel = {a_ALUSrcB, a_PCSource, a_ALUControl};
  assign b_sel = {b_ALUSrcB, b_PCSource, b_ALUControl};

  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_PC   = 7'b1000000;
  localparam logic [6:0] E_MW   = 7'b0100000;
  localparam logic [6:0] E_IR   = 7'b0010000;
  localparam logic [6:0] E_RW   = 7'b0001000;
  localparam logic [6:0] E_RD   = 7'b0000100;
  localparam logic [6:0] E_M2R  = 7'b0000010;
  localparam logic [6:0] E_H    = 7'b0000001;

  localparam logic [6:0] SEL_FETCH  = 7'b01_00_001;
  localparam logic [6:0] SEL_DECODE = 7'b11_00_001;
  localparam logic [6:0] SEL_R_ADD  = 7'b00_00_001;
  localparam logic [6:0] SEL_R_SUB  = 7'b00_00_010;
  localparam logic [6:0] SEL_IMM    = 7'b10_00_001;
  localparam logic [6:0] SEL_BRANCH = 7'b00_01_010;
  localparam logic [6:0] SEL_JUMP   = 7'b00_10_000;

  typedef struct {
    int         dut;
    string      tag;
    logic [3:0] st;
    logic [6:0] en;
    logic       care;
    logic [6:0] sel;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input string tag, input logic [3:0] st,
                      input logic [6:0] en, input logic care, input logic [6:0] sel);
    exp_t e;
    e.dut = d; e.tag = tag; e.st = st; e.en = en; e.care = care; e.sel = sel;
    sb.push_back(e);
  endtask

  // Pops one expectation per cycle and compares it against the named DUT.
  task automatic run();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      #1;
      chk({e.tag, ".state"}, {4'd0, (e.dut == 1) ? b_State : a_State}, {4'd0, e.st});
      chk({e.tag, ".en"}, {1'b0, (e.dut == 1) ? b_en : a_en}, {1'b0, e.en});
      if (e.care)
        chk({e.tag, ".sel"}, {1'b0, (e.dut == 1) ? b_sel : a_sel}, {1'b0, e.sel});
    end
  endtask

  task automatic front_end(input string tag);
    push(0, {tag, ".fetch"}, S_FETCH, E_PC, 1'b1, SEL_FETCH);
    push(0, {tag, ".fetch_ld"}, S_FETCH_LD, E_IR, 1'b0, 7'd0);
    push(0, {tag, ".decode"}, S_DECODE, E_NONE, 1'b1, SEL_DECODE);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, ".rst_state_a"}, {4'd0, a_State}, {4'd0, S_RESET});
    chk({tag, ".rst_en_a"}, {1'b0, a_en}, 8'd0);
    chk({tag, ".rst_state_b"}, {4'd0, b_State}, {4'd0, S_RESET});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk({tag, ".released"}, {4'd0, a_State}, {4'd0, S_RESET});
  endtask

  initial begin
    reset = 1'b0;
    #1;
    chk("por.state", {4'd0, a_State}, {4'd0, S_RESET});
    chk("por.en", {1'b0, a_en}, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("por.released", {4'd0, a_State}, {4'd0, S_RESET});

    OPCODE = OP_R; FUNCT = FN_ADD; Overflow = 1'b0;
    front_end("add");
    push(0, "add.r", S_R, E_NONE, 1'b1, SEL_R_ADD);
    push(0, "add.wb", S_WB_R, E_RW | E_RD, 1'b0, 7'd0);
    run();

    OPCODE = OP_ADDI;
    front_end("addi");
    push(0, "addi.ex", S_ADDI, E_NONE, 1'b1, SEL_IMM);
    push(0, "addi.wb", S_WB_I, E_RW, 1'b0, 7'd0);
    run();

    OPCODE = OP_J;
    front_end("j");
    push(0, "j.jump", S_JUMP, E_PC, 1'b1, SEL_JUMP);
    run();

    OPCODE = OP_BEQ; Zero = 1'b1;
    front_end("beq_z1");
    push(0, "beq_z1.br", S_BRANCH, E_PC, 1'b1, SEL_BRANCH);
    run();
    Zero = 1'b0;
    front_end("beq_z0");
    push(0, "beq_z0.br", S_BRANCH, E_NONE, 1'b1, SEL_BRANCH);
    run();
    OPCODE = OP_BNE; Zero = 1'b1;
    front_end("bne_z1");
    push(0, "bne_z1.br", S_BRANCH, E_NONE, 1'b1, SEL_BRANCH);
    run();
    Zero = 1'b0;
    front_end("bne_z0");
    push(0, "bne_z0.br", S_BRANCH, E_PC, 1'b1, SEL_BRANCH);
    push(0, "bne_z0.next", S_FETCH, E_PC, 1'b1, SEL_FETCH);
    run();

    OPCODE = OP_LW;
    push(0, "lw1.fetch_ld", S_FETCH_LD, E_IR, 1'b0, 7'd0);
    push(0, "lw1.decode", S_DECODE, E_NONE, 1'b1, SEL_DECODE);
    push(0, "lw1.addr", S_MEM_ADDR, E_NONE, 1'b1, SEL_IMM);
    push(0, "lw1.rd", S_MEM_RD, E_NONE, 1'b0, 7'd0);
    push(0, "lw1.wb", S_MEM_WB, E_RW | E_M2R, 1'b0, 7'd0);
    run();

    OPCODE = OP_SW;
    front_end("sw");
    push(0, "sw.addr", S_MEM_ADDR, E_NONE, 1'b1, SEL_IMM);
    push(0, "sw.wr", S_MEM_WR, E_MW, 1'b0, 7'd0);
    run();
    #2;
    reset = 1'b0;
    #1;
    chk("sw.async_memwrite", {7'd0, a_MemWrite}, 8'd0);
    chk("sw.async_state", {4'd0, a_State}, {4'd0, S_RESET});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    OPCODE = OP_R; FUNCT = FN_SUB; Overflow = 1'b1;
    front_end("sub_ovf");
    push(0, "sub_ovf.r", S_R, E_NONE, 1'b1, SEL_R_SUB);
    for (int i = 0; i < 11; i++) push(0, "sub_ovf.halt", S_HALT, E_H, 1'b0, 7'd0);
    run();

    Overflow = 1'b0;
    do_reset("rst2");
    OPCODE = 6'h3F;
    front_end("badop");
    for (int i = 0; i < 11; i++) push(0, "badop.halt", S_HALT, E_H, 1'b0, 7'd0);
    run();

    OPCODE = OP_LW;
    do_reset("rst3");
    push(1, "lw2.fetch0", S_FETCH, E_PC, 1'b1, SEL_FETCH);
    push(1, "lw2.fetch1", S_FETCH, E_PC, 1'b1, SEL_FETCH);
    push(1, "lw2.fetch_ld", S_FETCH_LD, E_IR, 1'b0, 7'd0);
    push(1, "lw2.decode", S_DECODE, E_NONE, 1'b1, SEL_DECODE);
    push(1, "lw2.addr", S_MEM_ADDR, E_NONE, 1'b1, SEL_IMM);
    push(1, "lw2.rd0", S_MEM_RD, E_NONE, 1'b0, 7'd0);
    push(1, "lw2.rd1", S_MEM_RD, E_NONE, 1'b0, 7'd0);
    push(1, "lw2.wb", S_MEM_WB, E_RW | E_M2R, 1'b0, 7'd0);
    push(1, "lw2.next", S_FETCH, E_PC, 1'b1, SEL_FETCH);
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
